// File: rtl/kernel_mac_seq.sv
// kernel_mac_seq: sequential multiply-accumulate over one KERNEL_SIZE x KERNEL_SIZE
// pixel window. The window is latched on a start pulse. The engine then walks the
// kernel buffer read port, one weight per cycle, and accumulates signed-weight x
// unsigned-pixel products. The result is handed downstream with a valid/ready
// handshake.
module kernel_mac_seq #(
    parameter int KERNEL_SIZE       = 3,
    parameter int KERNEL_ADDR_WIDTH = 5,
    parameter int WEIGHT_WIDTH      = 8,
    parameter int PIXEL_WIDTH       = 8,
    parameter int ACC_WIDTH         = 20
) (
    input  logic                                              i_clk,
    input  logic                                              i_rst,
    input  logic                                              i_start,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*PIXEL_WIDTH-1:0]    i_window,
    output logic [KERNEL_ADDR_WIDTH-1:0]                      o_kaddr,
    input  logic [WEIGHT_WIDTH-1:0]                           i_kdata,
    output logic                                              o_busy,
    output logic [ACC_WIDTH-1:0]                              o_result,
    output logic                                              o_valid,
    input  logic                                              i_ready
);

    localparam int N      = KERNEL_SIZE * KERNEL_SIZE;
    localparam int PROD_W = WEIGHT_WIDTH + PIXEL_WIDTH + 1;
    localparam int WIN_W  = N * PIXEL_WIDTH;
    localparam logic [KERNEL_ADDR_WIDTH-1:0] LAST_IDX = KERNEL_ADDR_WIDTH'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                         state_q, state_d;
    logic [KERNEL_ADDR_WIDTH-1:0]   idx_q;
    logic [WIN_W-1:0]               win_q;
    logic signed [ACC_WIDTH-1:0]    acc_q;

    logic [PIXEL_WIDTH-1:0]         pix;
    logic signed [PROD_W-1:0]       prod;
    logic signed [ACC_WIDTH-1:0]    prod_ext;

    // State register; reset returns to IDLE from anywhere, discarding any partial sum.
    always_ff @(posedge i_clk) begin
        if (!i_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic. A start in RUN or DONE (including on the handshake edge) is dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start)            state_d = RUN;
            RUN:     if (idx_q == LAST_IDX)  state_d = DONE;
            DONE:    if (i_ready)            state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    // Select the pixel that pairs with the current kernel address.
    always_comb begin
        pix = '0;
        for (int k = 0; k < N; k++) begin
            if (idx_q == KERNEL_ADDR_WIDTH'(k)) pix = win_q[k*PIXEL_WIDTH +: PIXEL_WIDTH];
        end
    end

    // The pixel is zero-extended into a signed operand. The product is exact at
    // PROD_W bits and is sign-extended before the wrapping add.
    always_comb begin
        prod     = PROD_W'($signed(i_kdata)) * PROD_W'($signed({1'b0, pix}));
        prod_ext = {{(ACC_WIDTH-PROD_W){prod[PROD_W-1]}}, prod};
    end

    // Datapath: latch the window on accept, then accumulate one tap per RUN cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            idx_q <= '0;
            win_q <= '0;
            acc_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        win_q <= i_window;
                        acc_q <= '0;
                        idx_q <= '0;
                    end
                end
                RUN: begin
                    acc_q <= acc_q + prod_ext;
                    idx_q <= idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // The kernel address is parked at 0 outside RUN. The result is the raw accumulator.
    always_comb begin
        o_kaddr  = (state_q == RUN) ? idx_q : '0;
        o_busy   = (state_q != IDLE);
        o_valid  = (state_q == DONE);
        o_result = acc_q;
    end

endmodule

// File: tb/tb_kernel_mac_seq.sv
// Self-checking bench for kernel_mac_seq. A behavioural kernel buffer drives
// i_kdata. Expected sums go into a queue at start time and are popped when
// o_valid is seen.
module tb_kernel_mac_seq;

    localparam int KS = 3;
    localparam int N  = KS * KS;
    localparam int AW = 5;

    logic              clk;
    logic              rst;
    logic              start;
    logic [N*8-1:0]    window;
    logic [AW-1:0]     kaddr;
    logic [7:0]        kdata;
    logic              busy;
    logic [19:0]       result;
    logic              valid;
    logic              ready;

    logic [7:0]        kmem [32];
    logic [19:0]       exp_q [$];
    int                n_checks;
    int                n_fail;

    kernel_mac_seq #(
        .KERNEL_SIZE(KS), .KERNEL_ADDR_WIDTH(AW), .WEIGHT_WIDTH(8),
        .PIXEL_WIDTH(8), .ACC_WIDTH(20)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_window(window),
        .o_kaddr(kaddr), .i_kdata(kdata), .o_busy(busy), .o_result(result),
        .o_valid(valid), .i_ready(ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign kdata = kmem[kaddr];

    function automatic logic [19:0] model(input logic [N*8-1:0] w);
        int s;
        int wv;
        int pv;
        s = 0;
        for (int k = 0; k < N; k++) begin
            wv = $signed(kmem[k]);
            pv = int'(w[k*8 +: 8]);
            s += wv * pv;
        end
        return s[19:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_weights(input int mode, input int val);
        for (int k = 0; k < 32; k++) kmem[k] = (mode == 0) ? 8'(val) : 8'($urandom_range(0, 255));
    endtask

    // Pulse start for exactly one edge and queue the expected sum for this window.
    task automatic do_start(input logic [N*8-1:0] w);
        window = w;
        start  = 1'b1;
        exp_q.push_back(model(w));
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (valid !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; ready = 1'b0; window = '0;
        tick(); tick();
        n_checks++;
        if ({valid, busy, kaddr, result} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b b=%b a=%0d r=%h want all 0", valid, busy, kaddr, result);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [N*8-1:0] w;
        logic [19:0] e;
        for (int k = 0; k < N; k++) w[k*8 +: 8] = 8'(k + 1);
        set_weights(0, 1);
        ready = 1'b1;
        do_start(w);
        for (int c = 0; c < N; c++) begin
            n_checks++;
            if (kaddr !== AW'(c) || valid !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_run_c%0d: got a=%0d v=%b b=%b want a=%0d v=0 b=1", c, kaddr, valid, busy, c);
            end
            tick();
        end
        e = exp_q.pop_front();
        n_checks++;
        if (valid !== 1'b1 || result !== 20'd45 || result !== e || kaddr !== '0) begin
            n_fail++;
            $display("FAIL basic_result: got v=%b r=%0d a=%0d want v=1 r=45 a=0", valid, result, kaddr);
        end
        tick();
        n_checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_handshake: got v=%b b=%b want 0 0", valid, busy);
        end
    endtask

    task automatic test_signed();
        int cyc;
        logic [19:0] e;
        ready = 1'b1;
        set_weights(0, -128);
        do_start({N{8'hFF}});
        wait_valid(cyc);
        e = exp_q.pop_front();
        n_checks++;
        if (valid !== 1'b1 || result !== 20'hB8480 || result !== e) begin
            n_fail++;
            $display("FAIL signed_neg: got v=%b r=%h want r=b8480 (cyc=%0d)", valid, result, cyc);
        end
        tick();
        set_weights(0, 127);
        do_start({N{8'hFF}});
        wait_valid(cyc);
        e = exp_q.pop_front();
        n_checks++;
        if (valid !== 1'b1 || result !== 20'd291465 || result !== e) begin
            n_fail++;
            $display("FAIL signed_pos: got v=%b r=%0d want r=291465", valid, result);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int cyc;
        int bad;
        logic [19:0] e;
        set_weights(1, 0);
        ready = 1'b0;
        do_start({$urandom, $urandom, 8'($urandom)});
        wait_valid(cyc);
        e = exp_q.pop_front();
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            if (valid !== 1'b1 || result !== e || busy !== 1'b1) bad++;
            tick();
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL backpressure_hold: %0d unstable cycles, r=%h want %h", bad, result, e);
        end
        n_checks++;
        if (valid !== 1'b1 || result !== e) begin
            n_fail++;
            $display("FAIL backpressure_still: got v=%b r=%h want v=1 r=%h", valid, result, e);
        end
        ready = 1'b1;
        tick();
        n_checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_release: got v=%b b=%b want 0 0", valid, busy);
        end
    endtask

    task automatic test_start_busy();
        int cyc;
        int extra;
        logic [19:0] e;
        logic [N*8-1:0] wa;
        logic [N*8-1:0] wb;
        set_weights(1, 0);
        wa = {$urandom, $urandom, 8'($urandom)};
        wb = ~wa;
        ready = 1'b0;
        do_start(wa);
        tick(); tick(); tick();
        start = 1'b1; window = wb;
        tick();
        start = 1'b0;
        wait_valid(cyc);
        e = exp_q.pop_front();
        n_checks++;
        if (valid !== 1'b1 || result !== e) begin
            n_fail++;
            $display("FAIL start_busy_run: got v=%b r=%h want v=1 r=%h", valid, result, e);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (valid !== 1'b1 || result !== e) begin
            n_fail++;
            $display("FAIL start_busy_done: got v=%b r=%h want v=1 r=%h", valid, result, e);
        end
        start = 1'b1; ready = 1'b1;
        tick();
        start = 1'b0;
        extra = 0;
        for (int c = 0; c < 15; c++) begin
            if (busy !== 1'b0 || valid !== 1'b0) extra++;
            tick();
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL start_busy_no_second: busy/valid seen %0d cycles want 0", extra);
        end
    endtask

    task automatic test_reset_midrun();
        int cyc;
        logic [19:0] e;
        set_weights(1, 0);
        ready = 1'b1;
        do_start({$urandom, $urandom, 8'($urandom)});
        tick(); tick(); tick(); tick();
        n_checks++;
        if (kaddr !== AW'(4)) begin
            n_fail++;
            $display("FAIL reset_mid_addr: got a=%0d want 4", kaddr);
        end
        void'(exp_q.pop_back());
        rst = 1'b0;
        tick();
        n_checks++;
        if ({valid, busy, kaddr, result} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got v=%b b=%b a=%0d r=%h want all 0", valid, busy, kaddr, result);
        end
        rst = 1'b1;
        tick();
        do_start({$urandom, $urandom, 8'($urandom)});
        wait_valid(cyc);
        e = exp_q.pop_front();
        n_checks++;
        if (valid !== 1'b1 || result !== e) begin
            n_fail++;
            $display("FAIL reset_mid_fresh: got v=%b r=%h want v=1 r=%h", valid, result, e);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [19:0] e;
        logic [N*8-1:0] wa;
        logic [N*8-1:0] wb;
        set_weights(1, 0);
        wa = {$urandom, $urandom, 8'($urandom)};
        wb = {$urandom, $urandom, 8'($urandom)};
        ready = 1'b1;
        do_start(wa);
        window = wb;
        for (int c = 0; c < N; c++) tick();
        e = exp_q.pop_front();
        n_checks++;
        if (valid !== 1'b1 || result !== e) begin
            n_fail++;
            $display("FAIL b2b_first: got v=%b r=%h want v=1 r=%h", valid, result, e);
        end
        tick();
        n_checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first_pulse: got v=%b b=%b want 0 0", valid, busy);
        end
        do_start(wb);
        window = ~wb;
        n_checks++;
        if (busy !== 1'b1 || kaddr !== '0) begin
            n_fail++;
            $display("FAIL b2b_second_accept: got b=%b a=%0d want b=1 a=0", busy, kaddr);
        end
        for (int c = 0; c < N; c++) tick();
        e = exp_q.pop_front();
        n_checks++;
        if (valid !== 1'b1 || result !== e) begin
            n_fail++;
            $display("FAIL b2b_second: got v=%b r=%h want v=1 r=%h", valid, result, e);
        end
        tick();
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second_pulse: got v=%b want 0", valid);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int k = 0; k < 32; k++) kmem[k] = '0;
        test_reset();
        test_basic();
        test_signed();
        test_backpressure();
        test_start_busy();
        test_reset_midrun();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
